clock_mode_ctrl: RTL

- Top-level mode sequencer for the digital clock. Turns single-cycle debounced button pulses into the 4-bit display/edit `state` consumed by the LED driver.
- Also issues the edit increment/decrement strobes, timer play/stop strobes, ring-cancel strobe and alarm-slot selection.
- Returns from any edit state to its parent display state on a button sequence or on an idle timeout.
- Sits between the button debouncers and the LED driver / alarm / countdown-timer blocks.

---
 rtl/clock_mode_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: turns debounced button pulses into the
// display/edit state, edit strobes, timer strobes, ring cancel and alarm-slot select.
module clock_mode_ctrl #(
  parameter int EDIT_TIMEOUT_S = 10,
  parameter int NUM_ALARMS     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sec_tick,
  input  logic       i_mode_btn,
  input  logic       i_set_btn,
  input  logic       i_up_btn,
  input  logic       i_down_btn,
  input  logic       i_ring_in,
  output logic [3:0] o_state,
  output logic       o_editing,
  output logic       o_inc_pulse,
  output logic       o_dec_pulse,
  output logic       o_play_pulse,
  output logic       o_stop_pulse,
  output logic       o_cancel_pulse,
  output logic [1:0] o_alarm_sel
);

  typedef enum logic [3:0] {
    TIME_DISP         = 4'd0,
    DATE_DISP         = 4'd1,
    TIME_EDIT_SECOND  = 4'd2,
    TIME_EDIT_MINUTE  = 4'd3,
    TIME_EDIT_HOUR    = 4'd4,
    TIME_EDIT_DAY     = 4'd5,
    TIME_EDIT_MONTH   = 4'd6,
    TIME_EDIT_YEAR    = 4'd7,
    ALARM_DISP        = 4'd8,
    ALARM_EDIT_SECOND = 4'd9,
    ALARM_EDIT_MINUTE = 4'd10,
    ALARM_EDIT_HOUR   = 4'd11,
    TIMER_DISP        = 4'd12,
    TIMER_EDIT_SECOND = 4'd13,
    TIMER_EDIT_MINUTE = 4'd14,
    TIMER_EDIT_HOUR   = 4'd15
  } state_t;

  localparam logic [7:0] TIMEOUT    = 8'(EDIT_TIMEOUT_S);
  localparam logic [1:0] LAST_ALARM = 2'(NUM_ALARMS - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_count, w_count_nxt;
  logic [1:0] r_alarm_sel, w_alarm_sel_nxt;
  logic       r_editing, w_editing_nxt;
  logic       r_inc, w_inc;
  logic       r_dec, w_dec;
  logic       r_play, w_play;
  logic       r_stop, w_stop;
  logic       r_cancel, w_cancel;

  logic w_set, w_mode, w_up, w_down, w_any;

  // Fixed priority set > mode > up > down; losers are simply dropped.
  assign w_set  = i_set_btn;
  assign w_mode = i_mode_btn & ~i_set_btn;
  assign w_up   = i_up_btn & ~i_set_btn & ~i_mode_btn;
  assign w_down = i_down_btn & ~i_set_btn & ~i_mode_btn & ~i_up_btn;
  assign w_any  = i_set_btn | i_mode_btn | i_up_btn | i_down_btn;

  function automatic logic isEdit(input state_t s);
    return !((s == TIME_DISP) || (s == DATE_DISP) || (s == ALARM_DISP) || (s == TIMER_DISP));
  endfunction

  function automatic state_t parentOf(input state_t s);
    case (s[3:2])
      2'b11:   return TIMER_DISP;
      2'b10:   return ALARM_DISP;
      default: return TIME_DISP;
    endcase
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_alarm_sel_nxt = r_alarm_sel;
    w_inc           = 1'b0;
    w_dec           = 1'b0;
    w_play          = 1'b0;
    w_stop          = 1'b0;
    w_cancel        = 1'b0;

    if (w_any) begin
      w_count_nxt = '0;
      if (i_ring_in) begin
        // While ringing, any button only acknowledges the ring.
        w_cancel = 1'b1;
      end else if (w_set) begin
        case (r_state)
          TIME_DISP:         w_state_nxt = TIME_EDIT_SECOND;
          DATE_DISP:         w_state_nxt = TIME_EDIT_DAY;
          ALARM_DISP:        w_state_nxt = ALARM_EDIT_SECOND;
          TIMER_DISP:        w_state_nxt = TIMER_EDIT_SECOND;
          TIME_EDIT_SECOND:  w_state_nxt = TIME_EDIT_MINUTE;
          TIME_EDIT_MINUTE:  w_state_nxt = TIME_EDIT_HOUR;
          TIME_EDIT_HOUR:    w_state_nxt = TIME_DISP;
          TIME_EDIT_DAY:     w_state_nxt = TIME_EDIT_MONTH;
          TIME_EDIT_MONTH:   w_state_nxt = TIME_EDIT_YEAR;
          TIME_EDIT_YEAR:    w_state_nxt = TIME_DISP;
          ALARM_EDIT_SECOND: w_state_nxt = ALARM_EDIT_MINUTE;
          ALARM_EDIT_MINUTE: w_state_nxt = ALARM_EDIT_HOUR;
          ALARM_EDIT_HOUR:   w_state_nxt = ALARM_DISP;
          TIMER_EDIT_SECOND: w_state_nxt = TIMER_EDIT_MINUTE;
          TIMER_EDIT_MINUTE: w_state_nxt = TIMER_EDIT_HOUR;
          TIMER_EDIT_HOUR:   w_state_nxt = TIMER_DISP;
          default:           w_state_nxt = r_state;
        endcase
      end else if (w_mode) begin
        case (r_state)
          TIME_DISP:  w_state_nxt = DATE_DISP;
          DATE_DISP:  w_state_nxt = ALARM_DISP;
          ALARM_DISP: w_state_nxt = TIMER_DISP;
          TIMER_DISP: w_state_nxt = TIME_DISP;
          default:    w_state_nxt = r_state;
        endcase
      end else if (r_editing) begin
        w_inc = w_up;
        w_dec = w_down;
      end else if (r_state == ALARM_DISP) begin
        if (w_up) begin
          w_alarm_sel_nxt = (r_alarm_sel == LAST_ALARM) ? 2'd0 : r_alarm_sel + 2'd1;
        end else begin
          w_alarm_sel_nxt = (r_alarm_sel == 2'd0) ? LAST_ALARM : r_alarm_sel - 2'd1;
        end
      end else if (r_state == TIMER_DISP) begin
        w_play = w_up;
        w_stop = w_down;
      end
    end else if (r_editing && (r_count == TIMEOUT)) begin
      w_state_nxt = parentOf(r_state);
      w_count_nxt = '0;
    end else if (r_editing && i_sec_tick) begin
      w_count_nxt = r_count + 8'd1;
    end
  end

  assign w_editing_nxt = isEdit(w_state_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TIME_DISP;
      r_count     <= '0;
      r_alarm_sel <= '0;
      r_editing   <= 1'b0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_play      <= 1'b0;
      r_stop      <= 1'b0;
      r_cancel    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_alarm_sel <= w_alarm_sel_nxt;
      r_editing   <= w_editing_nxt;
      r_inc       <= w_inc;
      r_dec       <= w_dec;
      r_play      <= w_play;
      r_stop      <= w_stop;
      r_cancel    <= w_cancel;
    end
  end

  assign o_state        = r_state;
  assign o_editing      = r_editing;
  assign o_inc_pulse    = r_inc;
  assign o_dec_pulse    = r_dec;
  assign o_play_pulse   = r_play;
  assign o_stop_pulse   = r_stop;
  assign o_cancel_pulse = r_cancel;
  assign o_alarm_sel    = r_alarm_sel;

endmodule
